// File: rtl/irq_pkg.sv
// Shared types for the interrupt acknowledge sequencer: bus codes, FSM states, request record.
// Latency: none (declarations only); backpressure: n/a.
package irq_pkg;

  localparam int BUS_W  = 2;
  localparam int CHAN_W = 4;

  localparam logic [BUS_W-1:0]  BUS_A    = 2'd0;
  localparam logic [BUS_W-1:0]  BUS_B    = 2'd1;
  localparam logic [BUS_W-1:0]  BUS_C    = 2'd2;
  localparam logic [CHAN_W-1:0] CHAN_MAX = 4'd8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_REQ,
    ST_SERVICE,
    ST_CLEAR,
    ST_HOLDOFF
  } state_t;

  typedef struct packed {
    logic              flag;
    logic [BUS_W-1:0]  bus;
    logic [CHAN_W-1:0] chan;
  } req_t;

  function automatic req_t mk_req(input logic pa, input logic pb, input logic pc,
                                  input logic [CHAN_W-1:0] chan);
    req_t r;
    r.flag = pa | pb | pc;
    r.bus  = pa ? BUS_A : (pb ? BUS_B : (pc ? BUS_C : BUS_A));
    r.chan = chan;
    return r;
  endfunction

  function automatic logic [5:0] pack_vec(input logic [BUS_W-1:0] bus,
                                          input logic [CHAN_W-1:0] chan);
    return {bus, chan};
  endfunction

endpackage

// File: rtl/irq_ack_sequencer_if.sv
// Encoder, CPU and pending-latch signals of the sequencer; master = sequencer side.
// Latency/backpressure: wiring only; ack/eoi from the CPU pace the handshake.
interface irq_ack_sequencer_if
  import irq_pkg::*;
#(
  parameter int VEC_W = 8
);
  logic              pa;
  logic              pb;
  logic              pc;
  logic [CHAN_W-1:0] chan;
  logic              irq;
  logic [VEC_W-1:0]  vector;
  logic              ack;
  logic              eoi;
  logic              in_service;
  logic              clr_valid;
  logic [BUS_W-1:0]  clr_bus;
  logic [CHAN_W-1:0] clr_chan;
  logic              timeout;
  logic              spurious;

  modport master (
    input  pa, pb, pc, chan, ack, eoi,
    output irq, vector, in_service, clr_valid, clr_bus, clr_chan, timeout, spurious
  );

  modport slave (
    output pa, pb, pc, chan, ack, eoi,
    input  irq, vector, in_service, clr_valid, clr_bus, clr_chan, timeout, spurious
  );
endinterface

// File: rtl/irq_cycle_counter.sv
// Saturating up-counter with synchronous load; tc means one more increment reaches TERM.
// Latency: count updates one edge after load/en; backpressure: none.
module irq_cycle_counter #(
  parameter int W    = 8,
  parameter int TERM = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         tc
);
  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != W'(TERM))) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count >= W'(TERM - 1));
endmodule

// File: rtl/irq_ack_sequencer.sv
// Samples the priority encoder, debounces it, raises irq+vector and runs ack/eoi/clear.
// Latency: irq 1+SETTLE_CYC edges after a stable flag; no backpressure, CPU ack/eoi pace it.
module irq_ack_sequencer
  import irq_pkg::*;
#(
  parameter int SETTLE_CYC  = 2,
  parameter int ACK_TIMEOUT = 255,
  parameter int VEC_W       = 8,
  parameter int VEC_BASE    = 0
) (
  input logic                 clk,
  input logic                 rst_n,
  irq_ack_sequencer_if.master io
);
  localparam logic [VEC_W-1:0] VEC_HI = VEC_W'(VEC_BASE) << 6;

  state_t            state_q, state_d;
  req_t              smp_q, cap_q, cap_d;
  logic              ack_q, eoi_q;
  logic              irq_q, irq_d;
  logic [VEC_W-1:0]  vec_q, vec_d;
  logic              insvc_q, insvc_d;
  logic              clr_q, clr_d;
  logic [BUS_W-1:0]  clr_bus_q, clr_bus_d;
  logic [CHAN_W-1:0] clr_chan_q, clr_chan_d;
  logic              timeout_q, timeout_d;
  logic              spur_q, spur_d;
  logic              set_load, set_en, set_tc;
  logic              to_load, to_en, to_tc;
  logic              smp_valid, smp_bad, smp_same;

  // Every input, ack/eoi included, passes one register so the FSM sees them aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_q <= '0;
      ack_q <= 1'b0;
      eoi_q <= 1'b0;
    end else begin
      smp_q <= mk_req(io.pa, io.pb, io.pc, io.chan);
      ack_q <= io.ack;
      eoi_q <= io.eoi;
    end
  end

  assign smp_valid = smp_q.flag && (smp_q.chan <= CHAN_MAX);
  assign smp_bad   = smp_q.flag && (smp_q.chan > CHAN_MAX);
  assign smp_same  = (smp_q.bus == cap_q.bus) && (smp_q.chan == cap_q.chan);

  irq_cycle_counter #(.W(4), .TERM(SETTLE_CYC)) u_settle_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (set_load),
    .en       (set_en),
    .load_val (4'd1),
    .tc       (set_tc)
  );

  irq_cycle_counter #(.W(8), .TERM(ACK_TIMEOUT)) u_ack_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (to_load),
    .en       (to_en),
    .load_val (8'd0),
    .tc       (to_tc)
  );

  always_comb begin
    state_d    = state_q;
    cap_d      = cap_q;
    irq_d      = irq_q;
    vec_d      = vec_q;
    insvc_d    = insvc_q;
    clr_d      = 1'b0;
    clr_bus_d  = '0;
    clr_chan_d = '0;
    timeout_d  = 1'b0;
    spur_d     = 1'b0;
    set_load   = 1'b0;
    set_en     = 1'b0;
    to_load    = 1'b0;
    to_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (smp_bad) begin
          spur_d = 1'b1;
        end else if (smp_valid) begin
          cap_d = smp_q;
          if (SETTLE_CYC == 1) begin
            state_d = ST_REQ;
            irq_d   = 1'b1;
            vec_d   = VEC_HI | VEC_W'(pack_vec(smp_q.bus, smp_q.chan));
            to_load = 1'b1;
          end else begin
            state_d  = ST_SETTLE;
            set_load = 1'b1;
          end
        end
      end
      ST_SETTLE: begin
        if (!smp_q.flag) begin
          state_d = ST_IDLE;
        end else if (smp_bad) begin
          spur_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (!smp_same) begin
          cap_d    = smp_q;
          set_load = 1'b1;
        end else if (set_tc) begin
          state_d = ST_REQ;
          irq_d   = 1'b1;
          vec_d   = VEC_HI | VEC_W'(pack_vec(cap_q.bus, cap_q.chan));
          to_load = 1'b1;
        end else begin
          set_en = 1'b1;
        end
      end
      ST_REQ: begin
        // ack outranks both a dropped flag and an expiring timeout.
        if (ack_q) begin
          state_d = ST_SERVICE;
          irq_d   = 1'b0;
          insvc_d = 1'b1;
        end else if (!smp_q.flag) begin
          state_d = ST_IDLE;
          irq_d   = 1'b0;
        end else if (to_tc) begin
          state_d   = ST_IDLE;
          irq_d     = 1'b0;
          timeout_d = 1'b1;
        end else begin
          to_en = 1'b1;
        end
      end
      ST_SERVICE: begin
        if (eoi_q) begin
          state_d    = ST_CLEAR;
          insvc_d    = 1'b0;
          clr_d      = 1'b1;
          clr_bus_d  = vec_q[5:4];
          clr_chan_d = vec_q[3:0];
        end
      end
      ST_CLEAR:   state_d = ST_HOLDOFF;
      ST_HOLDOFF: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cap_q      <= '0;
      irq_q      <= 1'b0;
      vec_q      <= '0;
      insvc_q    <= 1'b0;
      clr_q      <= 1'b0;
      clr_bus_q  <= '0;
      clr_chan_q <= '0;
      timeout_q  <= 1'b0;
      spur_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cap_q      <= cap_d;
      irq_q      <= irq_d;
      vec_q      <= vec_d;
      insvc_q    <= insvc_d;
      clr_q      <= clr_d;
      clr_bus_q  <= clr_bus_d;
      clr_chan_q <= clr_chan_d;
      timeout_q  <= timeout_d;
      spur_q     <= spur_d;
    end
  end

  assign io.irq        = irq_q;
  assign io.vector     = vec_q;
  assign io.in_service = insvc_q;
  assign io.clr_valid  = clr_q;
  assign io.clr_bus    = clr_bus_q;
  assign io.clr_chan   = clr_chan_q;
  assign io.timeout    = timeout_q;
  assign io.spurious   = spur_q;
endmodule

// File: tb/tb_irq_ack_sequencer.sv
// Directed bench for irq_ack_sequencer with SETTLE_CYC=2, ACK_TIMEOUT=4, VEC_BASE=0.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_irq_ack_sequencer;
  logic clk;
  logic rst_n;
  int   n_run;
  int   n_fail;

  irq_ack_sequencer_if #(.VEC_W(8)) bus_if ();

  irq_ack_sequencer #(
    .SETTLE_CYC  (2),
    .ACK_TIMEOUT (4),
    .VEC_W       (8),
    .VEC_BASE    (0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_run  = 0;
    n_fail = 0;
    clk    = 1'b0;
    rst_n  = 1'b0;
    bus_if.pa   = 1'b0;
    bus_if.pb   = 1'b0;
    bus_if.pc   = 1'b0;
    bus_if.chan = 4'd0;
    bus_if.ack  = 1'b0;
    bus_if.eoi  = 1'b0;
    #12;
    check_eq("rst_irq",      bus_if.irq,        0);
    check_eq("rst_vector",   bus_if.vector,     0);
    check_eq("rst_insvc",    bus_if.in_service, 0);
    check_eq("rst_clr",      bus_if.clr_valid,  0);
    check_eq("rst_timeout",  bus_if.timeout,    0);
    check_eq("rst_spurious", bus_if.spurious,   0);
    rst_n = 1'b1;
    tick();
    tick();

    // Bus B channel 5, ack on the timeout edge, then eoi.
    bus_if.pb = 1'b1; bus_if.chan = 4'd5;
    tick(); check_eq("t1_irq_e1", bus_if.irq, 0);
    tick(); check_eq("t1_irq_e2", bus_if.irq, 0);
    tick(); check_eq("t1_irq_e3", bus_if.irq, 1);
    check_eq("t1_vector", bus_if.vector, 32'h15);
    tick(); tick();
    bus_if.ack = 1'b1;
    tick(); check_eq("t1_irq_held", bus_if.irq, 1);
    bus_if.ack = 1'b0;
    tick();
    check_eq("t1_irq_ack", bus_if.irq, 0);
    check_eq("t1_insvc", bus_if.in_service, 1);
    check_eq("t1_no_timeout", bus_if.timeout, 0);
    check_eq("t1_vec_frozen", bus_if.vector, 32'h15);
    tick(); tick();
    bus_if.eoi = 1'b1;
    tick(); check_eq("t1_clr_early", bus_if.clr_valid, 0);
    bus_if.eoi = 1'b0; bus_if.pb = 1'b0;
    tick();
    check_eq("t1_clr", bus_if.clr_valid, 1);
    check_eq("t1_clr_bus", bus_if.clr_bus, 1);
    check_eq("t1_clr_chan", bus_if.clr_chan, 5);
    check_eq("t1_insvc_off", bus_if.in_service, 0);
    tick(); check_eq("t1_clr_once", bus_if.clr_valid, 0);
    tick(); tick();
    check_eq("t1_idle_irq", bus_if.irq, 0);

    // Bus C, channel changes after one sample: settle restarts.
    bus_if.pc = 1'b1; bus_if.chan = 4'd2;
    tick();
    bus_if.chan = 4'd7;
    tick(); check_eq("t2_irq_e2", bus_if.irq, 0);
    tick(); check_eq("t2_irq_e3", bus_if.irq, 0);
    tick(); check_eq("t2_irq_e4", bus_if.irq, 1);
    check_eq("t2_vector", bus_if.vector, 32'h27);
    bus_if.pc = 1'b0;
    tick(); check_eq("t2_irq_hold", bus_if.irq, 1);
    tick();
    check_eq("t2_drop_irq", bus_if.irq, 0);
    check_eq("t2_drop_clr", bus_if.clr_valid, 0);
    check_eq("t2_drop_to", bus_if.timeout, 0);
    tick(); tick();

    // Bus A channel 0, never acked: timeout after 4 REQ cycles, then re-raise.
    bus_if.pa = 1'b1; bus_if.chan = 4'd0;
    tick(); tick(); tick();
    check_eq("t3_irq_up", bus_if.irq, 1);
    check_eq("t3_vector", bus_if.vector, 32'h00);
    for (int i = 1; i <= 3; i++) begin
      tick(); check_eq($sformatf("t3_irq_c%0d", i), bus_if.irq, 1);
    end
    tick();
    check_eq("t3_timeout", bus_if.timeout, 1);
    check_eq("t3_irq_down", bus_if.irq, 0);
    tick();
    check_eq("t3_timeout_pulse", bus_if.timeout, 0);
    check_eq("t3_irq_idle", bus_if.irq, 0);
    tick(); check_eq("t3_reraise", bus_if.irq, 1);
    bus_if.pa = 1'b0;
    tick(); tick();
    check_eq("t3_irq_drop", bus_if.irq, 0);
    tick(); tick();

    // Out-of-range channel with a flag set.
    bus_if.pa = 1'b1; bus_if.chan = 4'd12;
    tick();
    bus_if.pa = 1'b0; bus_if.chan = 4'd0;
    tick();
    check_eq("t4_spurious", bus_if.spurious, 1);
    check_eq("t4_irq", bus_if.irq, 0);
    tick(); check_eq("t4_spur_pulse", bus_if.spurious, 0);
    tick(); tick(); tick();
    check_eq("t4_irq_never", bus_if.irq, 0);

    // Reset asserted while in service.
    bus_if.pb = 1'b1; bus_if.chan = 4'd3;
    tick(); tick(); tick();
    check_eq("t5_irq", bus_if.irq, 1);
    check_eq("t5_vector", bus_if.vector, 32'h13);
    bus_if.ack = 1'b1;
    tick();
    bus_if.ack = 1'b0;
    tick();
    check_eq("t5_insvc", bus_if.in_service, 1);
    bus_if.pb = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("t5_rst_insvc", bus_if.in_service, 0);
    check_eq("t5_rst_irq", bus_if.irq, 0);
    check_eq("t5_rst_vector", bus_if.vector, 0);
    tick();
    rst_n = 1'b1;
    bus_if.eoi = 1'b1;
    tick();
    bus_if.eoi = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(); check_eq($sformatf("t5_no_clr_%0d", i), bus_if.clr_valid, 0);
    end
    check_eq("t5_irq_idle", bus_if.irq, 0);

    // ack together with the flag dropping: ack wins, clear uses latched vector.
    bus_if.pa = 1'b1; bus_if.chan = 4'd4;
    tick(); tick(); tick();
    check_eq("t6_irq", bus_if.irq, 1);
    check_eq("t6_vector", bus_if.vector, 32'h04);
    bus_if.ack = 1'b1; bus_if.pa = 1'b0;
    tick();
    bus_if.ack = 1'b0;
    tick();
    check_eq("t6_insvc", bus_if.in_service, 1);
    check_eq("t6_irq_off", bus_if.irq, 0);
    tick();
    bus_if.eoi = 1'b1;
    tick();
    bus_if.eoi = 1'b0;
    tick();
    check_eq("t6_clr", bus_if.clr_valid, 1);
    check_eq("t6_clr_bus", bus_if.clr_bus, 0);
    check_eq("t6_clr_chan", bus_if.clr_chan, 4);
    tick();
    check_eq("t6_clr_once", bus_if.clr_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/irq_ack_sequencer.md
# irq_ack_sequencer

Sequential acknowledge stage downstream of the 27-channel combinational interrupt priority encoder (three request buses A/B/C of nine channels each). It samples the encoder's bus flags and 4-bit channel number, waits for a stable result, and raises a CPU interrupt carrying a vector. It then runs the ack/in-service/end-of-interrupt handshake and emits a one-cycle clear pulse back to the upstream pending-request latch.

## Interface
- SETTLE_CYC, 2: consecutive identical samples required before the interrupt is raised (1..15).
- ACK_TIMEOUT, 255: cycles in REQ without ack before abandoning (1..255).
- VEC_W, 8: vector width (>= 6).
- VEC_BASE, 0: upper VEC_W-6 vector bits.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- pa  in  1  encoder bus-A flag (highest priority).
- pb  in  1  encoder bus-B flag.
- pc  in  1  encoder bus-C flag (lowest priority).
- chan  in  4  encoder channel number, valid range 0..8.
- irq  out  1  interrupt request to CPU.
- vector  out  VEC_W  {VEC_BASE, bus[1:0], chan[3:0]}.
- ack  in  1  CPU acknowledge.
- eoi  in  1  CPU end-of-interrupt.
- in_service  out  1  a request has been acknowledged and not yet retired.
- clr_valid  out  1  one-cycle clear pulse to the pending latch.
- clr_bus  out  2  bus code of the cleared request.
- clr_chan  out  4  channel of the cleared request.
- timeout  out  1  one-cycle pulse: ack timeout.
- spurious  out  1  one-cycle pulse: chan > 8 with a flag set.

## Operation
- Inputs are registered once (sample stage). Bus code: A=0 if pa; else B=1 if pb; else C=2 if pc; none = no request. Code 3 is unused.
- States: IDLE, SETTLE, REQ, SERVICE, CLEAR, HOLDOFF.
- IDLE: any flag set -> SETTLE with counter=1 and the sample captured. A flag set with chan>8 -> pulse spurious and stay IDLE.
- SETTLE: the sample equals the captured one -> counter++. A different valid sample -> recapture, counter=1. No flag -> IDLE. Counter reaching SETTLE_CYC -> REQ; vector loaded, irq=1.
- REQ: vector stays frozen. ack=1 -> SERVICE; irq=0, in_service=1. Flags dropping with no ack -> IDLE, irq=0, no clear. ACK_TIMEOUT cycles without ack -> pulse timeout, irq=0, IDLE.
- SERVICE: input changes are ignored. eoi=1 -> CLEAR.
- CLEAR: clr_valid=1 for exactly one cycle, with clr_bus/clr_chan taken from the frozen vector. in_service=0. Next state HOLDOFF.
- HOLDOFF: one cycle so the pending-latch update propagates through the encoder. Then IDLE.
- ack outside REQ and eoi outside SERVICE are ignored.
- Simultaneous events:
  - ack and flag-drop in the same REQ cycle -> ack wins.
  - ack on the timeout cycle -> ack wins, no timeout pulse.
  - eoi with ack in SERVICE -> eoi honoured.
- Reset (any time, mid-handshake included): state IDLE. All outputs 0, including vector. Counters 0.

## Timing
- Flag set at edge N (registered at N+1) -> irq rises at edge N+1+SETTLE_CYC, given a stable input. With SETTLE_CYC=2, that is 3 cycles after the input edge.
- ack sampled at edge M -> irq=0 and in_service=1 after edge M.
- eoi sampled at edge K -> clr_valid high for the cycle after K. The next irq comes no earlier than K+3+SETTLE_CYC.
- Timeout counter runs only in REQ and restarts on each REQ entry.
- All outputs are registered. No combinational path from input to output.

## Structure
- Package irq_pkg holds:
  - bus codes (BUS_A=0, BUS_B=1, BUS_C=2);
  - CHAN_MAX=8;
  - the state enum;
  - a vector-packing function.
- Sub-module irq_cycle_counter: a saturating counter with load/enable/terminal-count. It is instantiated twice, once for settle and once for ack timeout.

## Test plan
- pb=1, chan=5, held; ack 2 cycles after irq; eoi 3 cycles later -> vector=0x15, irq 3 cycles after stimulus, clr_valid one cycle with clr_bus=1, clr_chan=5.
- pc=1, chan=2, changed to chan=7 after 1 sample -> settle restarts, vector=0x27, irq one cycle later than the unchanged case.
- pa=1, chan=0, no ack, ACK_TIMEOUT=4 -> irq high 4 cycles, timeout pulse, IDLE, re-raise after settle.
- pa=1, chan=12 -> spurious pulse, irq never asserts.
- rst_n low during SERVICE -> in_service=0, irq=0, vector=0 immediately; no clr_valid after release.
- ack and flag-drop on the same cycle -> SERVICE entered. A later eoi yields a clear of the latched vector.
